// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/fetch_ctrl_ret_stack.sv
// Return-address LIFO. Push/pop beyond capacity are ignored; the caller owns
// all error decisions.
module ret_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [W-1:0]   mem_q [DEPTH];
   logic [W-1:0]   mem_d [DEPTH];
   logic [PTR_W:0] cnt_q, cnt_d;
   logic [PTR_W:0] cnt_m1;

   assign cnt_m1 = cnt_q - 1'b1;
   assign full   = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty  = (cnt_q == '0);
   assign top    = mem_q[cnt_m1[PTR_W-1:0]];

   // Next occupancy and storage contents.
   always_comb begin
      mem_d = mem_q;
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (push && !full) begin
         mem_d[cnt_q[PTR_W-1:0]] = push_data;
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !empty) begin
         cnt_d = cnt_m1;
      end
   end

   // Occupancy register with synchronous reset; storage needs no reset.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: start/halt, stall, relative branch, absolute
// jump and call/return, with range checking and a RUN-cycle counter.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter  int unsigned ROM_SIZE    = 512,
   parameter  int unsigned OFF_W       = 6,
   parameter  int unsigned STACK_DEPTH = 4,
   parameter  int unsigned START_ADDR  = 0,
   localparam int unsigned ADDR_W      = $clog2(ROM_SIZE) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              halt,
   input  logic              br_taken,
   input  logic [OFF_W-1:0]  br_off,
   input  logic              jump,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] jump_tgt,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic [CNT_W-1:0]  cycle_cnt
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [ADDR_W:0]   npc;
   logic              err;
   logic              stk_push, stk_pop, stk_clear;
   logic              stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_top;

   ret_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (ADDR_W)
   ) u_ret_stack (
      .clk       (clk),
      .reset     (reset),
      .clear     (stk_clear),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (pc_q + 1'b1),
      .top       (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   // Next state, next PC, counter and stack control.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      npc       = '0;
      err       = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_clear = 1'b0;
      unique case (state_q)
         RUN: begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (!stall) begin
               if (halt) begin
                  state_d = DONE;
               end else begin
                  // Candidate PC is formed one bit wider so negative branch
                  // results and PC+1 overflow both show up as out of range.
                  if (ret) begin
                     err     = stk_empty;
                     npc     = {1'b0, stk_top};
                     stk_pop = 1'b1;
                  end else if (call) begin
                     err      = stk_full;
                     npc      = {1'b0, jump_tgt};
                     stk_push = 1'b1;
                  end else if (jump) begin
                     npc = {1'b0, jump_tgt};
                  end else if (br_taken) begin
                     npc = {1'b0, pc_q}
                         + {{(ADDR_W+1-OFF_W){br_off[OFF_W-1]}}, br_off};
                  end else begin
                     npc = {1'b0, pc_q} + 1'b1;
                  end
                  if (npc >= (ADDR_W+1)'(ROM_SIZE)) err = 1'b1;
                  if (err) begin
                     state_d  = FAULT;
                     stk_push = 1'b0;
                     stk_pop  = 1'b0;
                  end else begin
                     pc_d = npc[ADDR_W-1:0];
                  end
               end
            end
         end
         default: begin
            if (start) begin
               state_d   = RUN;
               pc_d      = ADDR_W'(START_ADDR);
               cnt_d     = '0;
               stk_clear = 1'b1;
            end
         end
      endcase
   end

   // State, PC and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= ADDR_W'(START_ADDR);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign instr_addr = pc_q;
   assign cycle_cnt  = cnt_q;
   assign busy       = (state_q == RUN);
   assign done       = (state_q == DONE);
   assign fault      = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model.
module tb_fetch_ctrl;

   localparam int ROM = 512;
   localparam int DEP = 4;

   logic       clk = 1'b0;
   logic       reset, start, stall, halt, br_taken, jump, call, ret;
   logic [5:0] br_off;
   logic [9:0] jump_tgt;
   logic [9:0] instr_addr;
   logic       busy, done, fault;
   logic [15:0] cycle_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: 0 idle, 1 run, 2 done, 3 fault.
   int m_state, m_pc, m_cnt;
   int m_stk[$];

   always #5 clk = ~clk;

   fetch_ctrl #(
      .ROM_SIZE    (512),
      .OFF_W       (6),
      .STACK_DEPTH (4),
      .START_ADDR  (0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stall      (stall),
      .halt       (halt),
      .br_taken   (br_taken),
      .br_off     (br_off),
      .jump       (jump),
      .call       (call),
      .ret        (ret),
      .jump_tgt   (jump_tgt),
      .instr_addr (instr_addr),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .cycle_cnt  (cycle_cnt)
   );

   task automatic clr_in();
      reset = 0; start = 0; stall = 0; halt = 0; br_taken = 0;
      jump = 0; call = 0; ret = 0; br_off = '0; jump_tgt = '0;
   endtask

   task automatic model_edge();
      int t;
      bit bad;
      if (reset) begin
         m_state = 0; m_pc = 0; m_cnt = 0; m_stk.delete();
      end else if (m_state != 1) begin
         if (start) begin
            m_state = 1; m_pc = 0; m_cnt = 0; m_stk.delete();
         end
      end else begin
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (!stall) begin
            if (halt) m_state = 2;
            else begin
               bad = 0; t = 0;
               if (ret) begin
                  if (m_stk.size() == 0) bad = 1; else t = m_stk[$];
               end else if (call) begin
                  if (m_stk.size() == DEP) bad = 1; else t = int'(jump_tgt);
               end else if (jump) t = int'(jump_tgt);
               else if (br_taken) t = m_pc + int'($signed(br_off));
               else t = m_pc + 1;
               if (!bad && (t < 0 || t >= ROM)) bad = 1;
               if (bad) m_state = 3;
               else begin
                  if (ret) void'(m_stk.pop_back());
                  else if (call) m_stk.push_back(m_pc + 1);
                  m_pc = t;
               end
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      clr_in(); reset = 1; cycle(); cycle(); reset = 0;
      n_tests++; if (instr_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", instr_addr); end
      n_tests++; if ({busy, done, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {busy, done, fault}); end
      n_tests++; if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", cycle_cnt); end
   endtask

   task automatic test_sequential();
      start = 1; cycle(); start = 0;
      n_tests++; if (instr_addr !== 10'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL start_pc got %0d/%b exp 0/1", instr_addr, busy); end
      for (int i = 1; i <= 5; i++) begin
         cycle();
         n_tests++; if (instr_addr !== 10'(i)) begin n_fail++; $display("FAIL seq_pc got %0d exp %0d", instr_addr, i); end
      end
      n_tests++; if (cycle_cnt !== 16'd5) begin n_fail++; $display("FAIL seq_cnt got %0d exp 5", cycle_cnt); end
      start = 1; cycle(); start = 0;
      n_tests++; if (instr_addr !== 10'd6 || cycle_cnt !== 16'd6) begin n_fail++; $display("FAIL start_in_run got %0d/%0d exp 6/6", instr_addr, cycle_cnt); end
   endtask

   task automatic test_branch();
      jump = 1; jump_tgt = 10'd20; cycle(); jump = 0;
      br_taken = 1; br_off = 6'h3A; cycle(); br_taken = 0;
      n_tests++; if (instr_addr !== 10'd14) begin n_fail++; $display("FAIL br_neg got %0d exp 14", instr_addr); end
      jump = 1; jump_tgt = 10'd20; cycle(); jump = 0;
      br_taken = 1; br_off = 6'd31; cycle(); br_taken = 0;
      n_tests++; if (instr_addr !== 10'd51) begin n_fail++; $display("FAIL br_pos got %0d exp 51", instr_addr); end
   endtask

   task automatic test_call_ret();
      jump = 1; jump_tgt = 10'd10; cycle(); jump = 0;
      call = 1; jump_tgt = 10'd100; cycle(); call = 0;
      n_tests++; if (instr_addr !== 10'd100) begin n_fail++; $display("FAIL call_tgt got %0d exp 100", instr_addr); end
      repeat (5) cycle();
      ret = 1; cycle();
      n_tests++; if (instr_addr !== 10'd11) begin n_fail++; $display("FAIL ret_addr got %0d exp 11", instr_addr); end
      cycle(); ret = 0;
      n_tests++; if (fault !== 1'b1 || busy !== 1'b0 || instr_addr !== 10'd11) begin n_fail++; $display("FAIL ret_empty got f=%b b=%b pc=%0d exp f=1 b=0 pc=11", fault, busy, instr_addr); end
   endtask

   task automatic test_overflow();
      start = 1; cycle(); start = 0;
      for (int i = 0; i < 5; i++) begin
         call = 1; jump_tgt = 10'(40 + 10 * i); cycle();
      end
      call = 0;
      n_tests++; if (fault !== 1'b1 || instr_addr !== 10'd70) begin n_fail++; $display("FAIL overflow got f=%b pc=%0d exp f=1 pc=70", fault, instr_addr); end
   endtask

   task automatic test_halt_priority();
      start = 1; cycle(); start = 0;
      jump = 1; jump_tgt = 10'd7; cycle();
      halt = 1; jump_tgt = 10'd30; cycle(); halt = 0; jump = 0;
      n_tests++; if (done !== 1'b1 || busy !== 1'b0 || instr_addr !== 10'd7) begin n_fail++; $display("FAIL halt got d=%b b=%b pc=%0d exp d=1 b=0 pc=7", done, busy, instr_addr); end
      repeat (2) cycle();
      n_tests++; if (cycle_cnt !== 16'd2 || done !== 1'b1) begin n_fail++; $display("FAIL done_hold got cnt=%0d d=%b exp cnt=2 d=1", cycle_cnt, done); end
      start = 1; cycle(); start = 0;
      n_tests++; if (instr_addr !== 10'd0 || done !== 1'b0 || busy !== 1'b1 || cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL restart got pc=%0d d=%b b=%b cnt=%0d exp 0/0/1/0", instr_addr, done, busy, cycle_cnt); end
   endtask

   task automatic test_range();
      jump = 1; jump_tgt = 10'd511; cycle(); jump = 0;
      n_tests++; if (instr_addr !== 10'd511) begin n_fail++; $display("FAIL top_addr got %0d exp 511", instr_addr); end
      cycle();
      n_tests++; if (fault !== 1'b1 || instr_addr !== 10'd511) begin n_fail++; $display("FAIL pc_wrap got f=%b pc=%0d exp f=1 pc=511", fault, instr_addr); end
      start = 1; cycle(); start = 0;
      jump = 1; jump_tgt = 10'd3; cycle(); jump = 0;
      br_taken = 1; br_off = 6'h3A; cycle(); br_taken = 0;
      n_tests++; if (fault !== 1'b1 || instr_addr !== 10'd3) begin n_fail++; $display("FAIL br_under got f=%b pc=%0d exp f=1 pc=3", fault, instr_addr); end
      start = 1; cycle(); start = 0;
      jump = 1; jump_tgt = 10'd600; cycle(); jump = 0;
      n_tests++; if (fault !== 1'b1 || instr_addr !== 10'd0) begin n_fail++; $display("FAIL jump_oor got f=%b pc=%0d exp f=1 pc=0", fault, instr_addr); end
   endtask

   task automatic test_stall_reset();
      start = 1; cycle(); start = 0;
      jump = 1; jump_tgt = 10'd9; cycle();
      stall = 1; jump_tgt = 10'd50;
      repeat (3) cycle();
      stall = 0; jump = 0;
      n_tests++; if (instr_addr !== 10'd9 || cycle_cnt !== 16'd4) begin n_fail++; $display("FAIL stall got pc=%0d cnt=%0d exp 9/4", instr_addr, cycle_cnt); end
      reset = 1; start = 1; cycle(); reset = 0; start = 0;
      n_tests++; if (instr_addr !== 10'd0 || {busy, done, fault} !== 3'b000 || cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reset got pc=%0d flags=%b cnt=%0d exp 0/000/0", instr_addr, {busy, done, fault}, cycle_cnt); end
   endtask

   task automatic test_random();
      clr_in(); reset = 1; cycle(); reset = 0;
      for (int i = 0; i < 600; i++) begin
         reset    = ($urandom_range(0, 99) == 0);
         start    = ($urandom_range(0, 9) == 0);
         stall    = ($urandom_range(0, 4) == 0);
         halt     = ($urandom_range(0, 39) == 0);
         ret      = ($urandom_range(0, 7) == 0);
         call     = ($urandom_range(0, 7) == 0);
         jump     = ($urandom_range(0, 9) == 0);
         br_taken = ($urandom_range(0, 3) == 0);
         br_off   = 6'($urandom);
         jump_tgt = 10'($urandom_range(0, 530));
         cycle();
         n_tests++; if (instr_addr !== 10'(m_pc)) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %0d exp %0d", i, instr_addr, m_pc); end
         n_tests++; if (busy !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b exp %b", i, busy, m_state == 1); end
         n_tests++; if (done !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_done cyc %0d got %b exp %b", i, done, m_state == 2); end
         n_tests++; if (fault !== (m_state == 3)) begin n_fail++; $display("FAIL rnd_fault cyc %0d got %b exp %b", i, fault, m_state == 3); end
         n_tests++; if (cycle_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, cycle_cnt, m_cnt); end
      end
      clr_in();
   endtask

   initial begin
      clr_in();
      m_state = 0; m_pc = 0; m_cnt = 0;
      test_reset();
      test_sequential();
      test_branch();
      test_call_ret();
      test_overflow();
      test_halt_priority();
      test_range();
      test_stall_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
